// File: rtl/responder_memoria_pkg.sv
// Shared definitions for responder_memoria: Control bit positions, FSM
// encoding and parameter defaults.
package responder_memoria_pkg;

  localparam int unsigned ANCHO_DIR_DEF = 8;
  localparam int unsigned ESPERAS_DEF   = 2;
  localparam int unsigned PILA_BASE_DEF = 'hC0;

  // Control = {Lee, Pila, Escribe, Busqueda, Estrobo, Dato}
  localparam int BIT_LEE      = 5;
  localparam int BIT_PILA     = 4;
  localparam int BIT_ESCRIBE  = 3;
  localparam int BIT_BUSQUEDA = 2;
  localparam int BIT_ESTROBO  = 1;
  localparam int BIT_DATO     = 0;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    ESPERA    = 2'd1,
    ACCESO    = 2'd2,
    RESPUESTA = 2'd3
  } estado_t;

endpackage

// File: rtl/responder_memoria_ram.sv
// ram_sincrona: single-port 2^ANCHO_DIR x 16 memory, synchronous read and write.
// Contents are deliberately not reset.
module ram_sincrona #(
  parameter int unsigned ANCHO_DIR = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ANCHO_DIR-1:0] addr_i,
  input  logic [15:0]          wdata_i,
  output logic [15:0]          rdata_o
);

  logic [15:0] mem_q [0:(2**ANCHO_DIR)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/responder_memoria.sv
// Memory responder: wait-state FSM in front of ram_sincrona with optional
// hardware stack, enabled by defining RESPONDER_MEMORIA_PILA_EN.
module responder_memoria
  import responder_memoria_pkg::*;
#(
  parameter int unsigned ANCHO_DIR = ANCHO_DIR_DEF,
  parameter int unsigned ESPERAS   = ESPERAS_DEF,
  parameter int unsigned PILA_BASE = PILA_BASE_DEF
) (
  input  logic                 Reloj,
  input  logic                 Reiniciar,
  input  logic [5:0]           Control,
  input  logic [ANCHO_DIR-1:0] Direccion,
  input  logic [15:0]          DatoEscrito,
  output logic [15:0]          DatoLeido,
  output logic                 Listo,
  output logic                 Ocupado,
  output logic                 ErrorBus,
  output logic [ANCHO_DIR-1:0] PunteroPila
);

  localparam logic [3:0]           ULTIMA = 4'((ESPERAS > 0) ? ESPERAS - 1 : 0);
  localparam logic [ANCHO_DIR-1:0] BASE   = ANCHO_DIR'(PILA_BASE);
  localparam logic [ANCHO_DIR-1:0] UNO    = ANCHO_DIR'(1);

  estado_t              estado_q, estado_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ANCHO_DIR-1:0] dir_q, dir_d;
  logic [15:0]          dato_q, dato_d;
  logic                 esc_q, esc_d;
  logic                 pila_q, pila_d;
  logic [ANCHO_DIR-1:0] sp_q, sp_d;
  logic [15:0]          leido_q, leido_d;
  logic                 listo_q, listo_d;
  logic                 error_q, error_d;

  logic                 lee, esc, legal, acepta, pila_in, falla;
  logic [ANCHO_DIR-1:0] dir_sel;
  logic [15:0]          rdata;

  assign lee    = Control[BIT_LEE];
  assign esc    = Control[BIT_ESCRIBE];
  // Fetch is a read variant: Busqueda without Lee is illegal.
  assign legal  = (lee ^ esc) & ~(Control[BIT_BUSQUEDA] & ~lee);
  assign acepta = Control[BIT_ESTROBO] & ~Ocupado;

`ifdef RESPONDER_MEMORIA_PILA_EN
  logic unused_dato;
  assign unused_dato = Control[BIT_DATO];
  assign pila_in     = Control[BIT_PILA];
  assign falla       = pila_in & ((lee & (sp_q == '0)) | (esc & (sp_q == BASE)));
`else
  logic [2:0] unused_cfg;
  assign unused_cfg = {Control[BIT_PILA], Control[BIT_DATO], (BASE == '0)};
  assign pila_in    = 1'b0;
  assign falla      = 1'b0;
`endif

  // Push stores below the pointer, pop reads at it.
  assign dir_sel = pila_in ? (esc ? sp_q - UNO : sp_q) : Direccion;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    dato_d   = dato_q;
    esc_d    = esc_q;
    pila_d   = pila_q;
    sp_d     = sp_q;
    leido_d  = leido_q;
    listo_d  = 1'b0;
    error_d  = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (acepta) begin
          if (!legal || falla) begin
            error_d = 1'b1;
          end else begin
            dir_d    = dir_sel;
            dato_d   = DatoEscrito;
            esc_d    = esc;
            pila_d   = pila_in;
            estado_d = (ESPERAS > 0) ? ESPERA : ACCESO;
          end
        end
      end
      ESPERA: begin
        if (cnt_q == ULTIMA) begin
          cnt_d    = '0;
          estado_d = ACCESO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESO: begin
        estado_d = RESPUESTA;
        if (pila_q) sp_d = esc_q ? sp_q - UNO : sp_q + UNO;
      end
      RESPUESTA: begin
        estado_d = REPOSO;
        listo_d  = 1'b1;
        if (!esc_q) leido_d = rdata;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) begin
      estado_q <= REPOSO;
      cnt_q    <= '0;
      dir_q    <= '0;
      dato_q   <= '0;
      esc_q    <= 1'b0;
      pila_q   <= 1'b0;
      sp_q     <= '0;
      leido_q  <= '0;
      listo_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
      esc_q    <= esc_d;
      pila_q   <= pila_d;
      sp_q     <= sp_d;
      leido_q  <= leido_d;
      listo_q  <= listo_d;
      error_q  <= error_d;
    end
  end

  ram_sincrona #(.ANCHO_DIR(ANCHO_DIR)) u_ram (
    .clk_i   (Reloj),
    .we_i    ((estado_q == ACCESO) &  esc_q),
    .re_i    ((estado_q == ACCESO) & ~esc_q),
    .addr_i  (dir_q),
    .wdata_i (dato_q),
    .rdata_o (rdata)
  );

  // Busy extends through the Listo cycle so no request overlaps the response.
  assign Ocupado     = (estado_q != REPOSO) | listo_q;
  assign DatoLeido   = leido_q;
  assign Listo       = listo_q;
  assign ErrorBus    = error_q;
  assign PunteroPila = sp_q;

endmodule

// File: tb/tb_responder_memoria.sv
// Directed bench for responder_memoria: scoreboard of expected responses,
// two instances (ESPERAS=2 and ESPERAS=0).
module tb_responder_memoria;

  localparam logic [5:0] WR   = 6'b001010;
  localparam logic [5:0] RD   = 6'b100010;
  localparam logic [5:0] RDD  = 6'b100011;
  localparam logic [5:0] FE   = 6'b100110;
  localparam logic [5:0] ILL  = 6'b101010;
  localparam logic [5:0] ILL2 = 6'b001110;
  localparam logic [5:0] PUSH = 6'b011010;
  localparam logic [5:0] POP  = 6'b110010;

  logic        Reloj = 1'b0;
  logic        Reiniciar;
  logic [5:0]  ctrl_a, ctrl_b;
  logic [7:0]  Direccion;
  logic [15:0] DatoEscrito;
  logic [15:0] leido_a, leido_b;
  logic        listo_a, listo_b, ocup_a, ocup_b, err_a, err_b;
  logic [7:0]  sp_a, sp_b;

  always #5 Reloj = ~Reloj;

  responder_memoria #(.ESPERAS(2)) dut_a (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Control(ctrl_a), .Direccion(Direccion),
    .DatoEscrito(DatoEscrito), .DatoLeido(leido_a), .Listo(listo_a), .Ocupado(ocup_a),
    .ErrorBus(err_a), .PunteroPila(sp_a));

  responder_memoria #(.ESPERAS(0)) dut_b (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Control(ctrl_b), .Direccion(Direccion),
    .DatoEscrito(DatoEscrito), .DatoLeido(leido_b), .Listo(listo_b), .Ocupado(ocup_b),
    .ErrorBus(err_b), .PunteroPila(sp_b));

  bit          sel = 1'b0;
  logic        listo_s, ocup_s, err_s;
  logic [15:0] leido_s;
  logic [7:0]  sp_s;
  assign listo_s = sel ? listo_b : listo_a;
  assign ocup_s  = sel ? ocup_b  : ocup_a;
  assign err_s   = sel ? err_b   : err_a;
  assign leido_s = sel ? leido_b : leido_a;
  assign sp_s    = sel ? sp_b    : sp_a;

  int ciclo = 0;
  always @(posedge Reloj) ciclo <= ciclo + 1;

  typedef struct {
    bit          err;
    bit          rd;
    logic [15:0] dato;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int          total = 0, pass_cnt = 0, fail_cnt = 0;
  int          ciclo_ini = 0;
  logic [15:0] ultimo = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic conducir(input logic [5:0] c, input logic [7:0] d, input logic [15:0] w);
    @(negedge Reloj);
    Direccion = d; DatoEscrito = w;
    if (sel) ctrl_b = c; else ctrl_a = c;
    @(negedge Reloj);
    ctrl_a = '0; ctrl_b = '0;
    Direccion = 8'($urandom); DatoEscrito = 16'($urandom);
    ciclo_ini = ciclo;
  endtask

  task automatic esperar();
    exp_t e;
    int   n;
    n = 0;
    while (!(listo_s || err_s) && n < 40) begin
      @(negedge Reloj);
      n++;
    end
    chk("evento", 32'(listo_s | err_s), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_vacio", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("es_error", 32'(err_s), 32'(e.err));
      chk("es_listo", 32'(listo_s), 32'(!e.err));
      chk("latencia", 32'(ciclo - ciclo_ini), 32'(e.lat));
      chk("ocupado_en_respuesta", 32'(ocup_s), 32'(!e.err));
      if (e.rd) chk("dato_leido", 32'(leido_s), 32'(e.dato));
    end
    @(negedge Reloj);
    chk("pulso_unico", 32'(listo_s | err_s), 32'd0);
    chk("ocupado_fin", 32'(ocup_s), 32'd0);
  endtask

  task automatic transaccion(input logic [5:0] c, input logic [7:0] d, input logic [15:0] w,
                             input bit err, input bit lectura);
    exp_t e;
    e.err  = err;
    e.rd   = 1'b1;
    e.dato = (lectura && !err) ? w : ultimo;
    e.lat  = err ? 0 : (sel ? 2 : 4);
    if (lectura && !err) ultimo = w;
    sb.push_back(e);
    conducir(c, d, (lectura ? 16'h0 : w));
    esperar();
  endtask

  initial begin
    exp_t e;
    int   extra;
    Reiniciar = 1'b1; ctrl_a = '0; ctrl_b = '0; Direccion = '0; DatoEscrito = '0;
    @(negedge Reloj);
    chk("rst_dato", 32'(leido_a), 32'd0);
    chk("rst_listo", 32'(listo_a), 32'd0);
    chk("rst_ocupado", 32'(ocup_a), 32'd0);
    chk("rst_error", 32'(err_a), 32'd0);
    chk("rst_puntero", 32'(sp_a), 32'd0);
    @(negedge Reloj);
    Reiniciar = 1'b0;

    // Reads pass the expected data as w; the bench drives zero instead.
    transaccion(WR,   8'h10, 16'hBEEF, 1'b0, 1'b0);
    transaccion(RD,   8'h10, 16'hBEEF, 1'b0, 1'b1);
    transaccion(ILL,  8'h10, 16'h0BAD, 1'b1, 1'b0);
    transaccion(RD,   8'h10, 16'hBEEF, 1'b0, 1'b1);
    transaccion(ILL2, 8'h10, 16'h0BAD, 1'b1, 1'b0);
    transaccion(FE,   8'h10, 16'hBEEF, 1'b0, 1'b1);
    transaccion(WR,   8'h30, 16'h1111, 1'b0, 1'b0);
    transaccion(RDD,  8'h30, 16'h1111, 1'b0, 1'b1);

    // Second strobe while busy must be ignored.
    transaccion(WR, 8'h40, 16'h0A0A, 1'b0, 1'b0);
    e.err = 1'b0; e.rd = 1'b1; e.dato = ultimo; e.lat = 4;
    sb.push_back(e);
    conducir(WR, 8'h40, 16'h5555);
    @(negedge Reloj);
    Direccion = 8'h40; DatoEscrito = 16'h7777; ctrl_a = WR;
    @(negedge Reloj);
    ctrl_a = '0;
    esperar();
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Reloj);
      if (listo_a) extra++;
    end
    chk("listo_extra", 32'(extra), 32'd0);
    transaccion(RD, 8'h40, 16'h5555, 1'b0, 1'b1);

    // Reset during the wait phase of a write aborts it.
    transaccion(WR, 8'h20, 16'hAAAA, 1'b0, 1'b0);
    conducir(WR, 8'h20, 16'h3333);
    #1 Reiniciar = 1'b1;
    #1;
    chk("rst_medio_ocupado", 32'(ocup_a), 32'd0);
    chk("rst_medio_dato", 32'(leido_a), 32'd0);
    @(negedge Reloj);
    Reiniciar = 1'b0;
    ultimo = 16'h0;
    transaccion(RD, 8'h20, 16'hAAAA, 1'b0, 1'b1);

`ifdef RESPONDER_MEMORIA_PILA_EN
    transaccion(POP, 8'h00, 16'h0, 1'b1, 1'b0);
    chk("sp_pop_vacio", 32'(sp_a), 32'h00);
    transaccion(PUSH, 8'h00, 16'h1234, 1'b0, 1'b0);
    chk("sp_push1", 32'(sp_a), 32'hFF);
    transaccion(PUSH, 8'h00, 16'h5678, 1'b0, 1'b0);
    chk("sp_push2", 32'(sp_a), 32'hFE);
    transaccion(POP, 8'h00, 16'h5678, 1'b0, 1'b1);
    chk("sp_pop1", 32'(sp_a), 32'hFF);
    transaccion(POP, 8'h00, 16'h1234, 1'b0, 1'b1);
    chk("sp_pop2", 32'(sp_a), 32'h00);
    transaccion(WR, 8'hBF, 16'hBFBF, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) transaccion(PUSH, 8'h00, 16'(i), 1'b0, 1'b0);
    chk("sp_lleno", 32'(sp_a), 32'hC0);
    transaccion(PUSH, 8'h00, 16'hDEAD, 1'b1, 1'b0);
    chk("sp_push_lleno", 32'(sp_a), 32'hC0);
    transaccion(RD, 8'hBF, 16'hBFBF, 1'b0, 1'b1);
`else
    transaccion(PUSH, 8'h60, 16'h6060, 1'b0, 1'b0);
    chk("sp_sin_pila_push", 32'(sp_a), 32'h00);
    transaccion(POP, 8'h60, 16'h6060, 1'b0, 1'b1);
    chk("sp_sin_pila_pop", 32'(sp_a), 32'h00);
`endif

    // Zero-wait instance.
    sel = 1'b1;
    ultimo = 16'h0;
    transaccion(WR, 8'h50, 16'hC0DE, 1'b0, 1'b0);
    transaccion(RD, 8'h50, 16'hC0DE, 1'b0, 1'b1);
    transaccion(ILL, 8'h50, 16'h0, 1'b1, 1'b0);

    chk("scoreboard_final", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
